dmem_responder: RTL and testbench

//  Responder end of the execute-memory stage's data-memory interface: accepts read/write/stack/PC-stack requests and owns the stack pointer.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_ram.sv | 16 +
 rtl/dmem_responder.sv | 103 ++++++++++
 tb/tb_dmem_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: request op encodings, FSM states and default widths shared by dmem_responder.
package dmem_pkg;
  localparam int DMEM_DATA_WIDTH = 16;
  localparam int DMEM_ADDR_WIDTH = 11;
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_READ    = 3'd1,
    OP_WRITE   = 3'd2,
    OP_PUSH    = 3'd3,
    OP_POP     = 3'd4,
    OP_PUSH_PC = 3'd5,
    OP_POP_PC  = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;
  typedef enum logic {S_IDLE, S_BEAT2} state_e;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM, one write or one registered read per cycle.
module dmem_ram #(
  parameter int DW = 16,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wd;
    else q <= mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with a down-growing stack and two-beat PC push/pop.
// Define DMEM_ADDR_CHECK_EN to reject READ/WRITE addresses beyond the RAM and add o_addr_error.
module dmem_responder import dmem_pkg::*; #(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] SP_RESET = ADDR_WIDTH'(11'h7FF),
  parameter logic [ADDR_WIDTH-1:0] STACK_LIMIT = ADDR_WIDTH'(11'h400)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [2:0]            i_req_op,
  input  logic [15:0]           i_address,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [31:0]           i_pc,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic [31:0]           o_pc_data,
  output logic [ADDR_WIDTH-1:0] o_sp,
`ifdef DMEM_ADDR_CHECK_EN
  output logic                  o_addr_error,
`endif
  output logic                  o_stack_error
);
  state_e state;
  op_e op;
  logic [ADDR_WIDTH-1:0] sp, sp_n, addr2, ram_addr;
  logic [DATA_WIDTH-1:0] ram_q, ram_wd;
  logic [15:0] lo_q;
  logic accept, is_pc, fault, addr_bad, ram_we, rd_sel, pc_sel, pc_pop, pc_fault;
  assign op = op_e'(i_req_op);
  assign o_req_ready = i_reset && state == S_IDLE;
  assign accept = i_req_valid && o_req_ready;
  assign is_pc = op == OP_PUSH_PC || op == OP_POP_PC;
  assign o_sp = sp;
`ifdef DMEM_ADDR_CHECK_EN
  assign addr_bad = |i_address[15:ADDR_WIDTH];
  always_ff @(posedge i_clk)
    o_addr_error <= accept && (op == OP_READ || op == OP_WRITE) && addr_bad;
`else
  logic unused_addr;
  assign addr_bad = 1'b0;
  assign unused_addr = ^i_address[15:ADDR_WIDTH];
`endif
  // Overflow/underflow bounds keep SP from ever wrapping.
  assign fault = (op == OP_PUSH && sp <= STACK_LIMIT) ||
                 (op == OP_PUSH_PC && (sp <= STACK_LIMIT || sp == STACK_LIMIT + 1'b1)) ||
                 (op == OP_POP && sp == SP_RESET) ||
                 (op == OP_POP_PC && (sp == SP_RESET || sp == SP_RESET - 1'b1));
  assign sp_n = fault ? sp :
                op == OP_PUSH ? sp - 1'b1 :
                op == OP_POP ? sp + 1'b1 :
                op == OP_PUSH_PC ? sp - 2'd2 :
                op == OP_POP_PC ? sp + 2'd2 : sp;
  assign ram_addr = state == S_BEAT2 ? addr2 :
                    (op == OP_READ || op == OP_WRITE) ? i_address[ADDR_WIDTH-1:0] :
                    (op == OP_PUSH || op == OP_PUSH_PC) ? sp : sp + 1'b1;
  assign ram_we = i_reset && (state == S_BEAT2 ? !pc_pop && !pc_fault :
                  accept && !fault && ((op == OP_WRITE && !addr_bad) || op == OP_PUSH || op == OP_PUSH_PC));
  assign ram_wd = state == S_BEAT2 ? DATA_WIDTH'(lo_q) :
                  op == OP_PUSH_PC ? DATA_WIDTH'(i_pc[31:16]) : i_write_data;
  assign o_read_data = rd_sel ? ram_q : '0;
  assign o_pc_data = pc_sel ? {16'(ram_q), lo_q} : '0;
  dmem_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
    .clk  (i_clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wd   (ram_wd),
    .q    (ram_q)
  );
  // lo_q carries the low PC half: to be written on a push, or as read back on a pop.
  always_ff @(posedge i_clk)
    if (!i_reset) begin
      state <= S_IDLE;
      sp <= SP_RESET;
      o_rsp_valid <= 1'b0;
      rd_sel <= 1'b0;
      pc_sel <= 1'b0;
      o_stack_error <= 1'b0;
    end else if (state == S_BEAT2) begin
      state <= S_IDLE;
      o_rsp_valid <= 1'b1;
      rd_sel <= 1'b0;
      pc_sel <= pc_pop && !pc_fault;
      lo_q <= 16'(ram_q);
    end else begin
      o_rsp_valid <= accept && !is_pc;
      rd_sel <= accept && !fault && (op == OP_POP || (op == OP_READ && !addr_bad));
      pc_sel <= 1'b0;
      if (accept) begin
        sp <= sp_n;
        o_stack_error <= o_stack_error || fault;
        if (is_pc) begin
          state <= S_BEAT2;
          pc_pop <= op == OP_POP_PC;
          pc_fault <= fault;
          addr2 <= op == OP_POP_PC ? sp + 2'd2 : sp - 1'b1;
          lo_q <= i_pc[15:0];
        end
      end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table, PC/reset corner sequences and a random run
// against a stack-queue reference model for dmem_responder.
module tb_dmem_responder;
  localparam logic [2:0] NOP = 3'd0, RD = 3'd1, WR = 3'd2, PUSH = 3'd3, POP = 3'd4, PPC = 3'd5, OPC = 3'd6, RSV = 3'd7;
  localparam int SPR = 'h7FF, LIM = 'h400;
`ifdef DMEM_ADDR_CHECK_EN
  localparam bit ACHK = 1'b1;
  logic addr_error;
`else
  localparam bit ACHK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, ready, rsp_valid, stack_error;
  logic [2:0] op = '0;
  logic [15:0] address = '0, wdata = '0, read_data;
  logic [31:0] pc = '0, pc_data;
  logic [10:0] sp;
  int checks = 0, errors = 0;
  logic [15:0] ram_m [32];
  logic [15:0] stk [$];
  bit err_m;
  typedef struct {
    logic [2:0] op;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] data;
    logic [10:0] sp;
    logic err;
  } vec_t;
  vec_t tbl [$];
  always #5 clk = ~clk;
  dmem_responder dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_req_valid   (valid),
    .o_req_ready   (ready),
    .i_req_op      (op),
    .i_address     (address),
    .i_write_data  (wdata),
    .i_pc          (pc),
    .o_rsp_valid   (rsp_valid),
    .o_read_data   (read_data),
    .o_pc_data     (pc_data),
    .o_sp          (sp),
`ifdef DMEM_ADDR_CHECK_EN
    .o_addr_error  (addr_error),
`endif
    .o_stack_error (stack_error)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    step();
    step();
    chk("reset_ready", ready, 0);
    chk("reset_rsp", rsp_valid, 0);
    chk("reset_sp", sp, SPR);
    chk("reset_err", stack_error, 0);
    rst_n = 1'b1;
    #1;
    chk("release_ready", ready, 1);
  endtask
  task automatic chk_aerr(input string name, input logic [2:0] o, input logic [15:0] a);
`ifdef DMEM_ADDR_CHECK_EN
    chk(name, addr_error, (o == RD || o == WR) && a[15:11] != 0);
`endif
  endtask
  task automatic pc_op(input string name, input logic [2:0] o, input logic [31:0] v,
                       input logic [31:0] epc, input int esp, input logic eerr);
    valid = 1'b1;
    op = o;
    pc = v;
    step();
    chk({name, "_b2_ready"}, ready, 0);
    chk({name, "_b2_rsp"}, rsp_valid, 0);
    step();
    chk({name, "_rsp"}, rsp_valid, 1);
    chk({name, "_ready"}, ready, 1);
    chk({name, "_pc"}, pc_data, epc);
    chk({name, "_sp"}, sp, esp);
    chk({name, "_err"}, stack_error, eerr);
    valid = 1'b0;
  endtask
  initial begin
    tbl.push_back('{WR,  16'h0010, 16'hBEEF, 16'h0000, 11'h7FF, 1'b0});
    tbl.push_back('{RD,  16'h0010, 16'h0000, 16'hBEEF, 11'h7FF, 1'b0});
    tbl.push_back('{WR,  16'h0020, 16'hCAFE, 16'h0000, 11'h7FF, 1'b0});
    tbl.push_back('{RD,  16'h0020, 16'h0000, 16'hCAFE, 11'h7FF, 1'b0});
    tbl.push_back('{RD,  16'h0810, 16'h0000, ACHK ? 16'h0000 : 16'hBEEF, 11'h7FF, 1'b0});
    tbl.push_back('{WR,  16'h0820, 16'h1111, 16'h0000, 11'h7FF, 1'b0});
    tbl.push_back('{RD,  16'h0020, 16'h0000, ACHK ? 16'hCAFE : 16'h1111, 11'h7FF, 1'b0});
    tbl.push_back('{PUSH, 16'h0000, 16'h1234, 16'h0000, 11'h7FE, 1'b0});
    tbl.push_back('{PUSH, 16'h0000, 16'h5678, 16'h0000, 11'h7FD, 1'b0});
    tbl.push_back('{POP, 16'h0000, 16'h0000, 16'h5678, 11'h7FE, 1'b0});
    tbl.push_back('{POP, 16'h0000, 16'h0000, 16'h1234, 11'h7FF, 1'b0});
    tbl.push_back('{NOP, 16'h0010, 16'hFFFF, 16'h0000, 11'h7FF, 1'b0});
    tbl.push_back('{RSV, 16'h0010, 16'hFFFF, 16'h0000, 11'h7FF, 1'b0});
    tbl.push_back('{POP, 16'h0000, 16'h0000, 16'h0000, 11'h7FF, 1'b1});
    tbl.push_back('{NOP, 16'h0000, 16'h0000, 16'h0000, 11'h7FF, 1'b1});
    tbl.push_back('{RD,  16'h0010, 16'h0000, 16'hBEEF, 11'h7FF, 1'b1});
    do_reset();
    foreach (tbl[i]) begin
      valid = 1'b1;
      op = tbl[i].op;
      address = tbl[i].addr;
      wdata = tbl[i].wd;
      step();
      chk($sformatf("tbl%0d_rsp", i), rsp_valid, 1);
      chk($sformatf("tbl%0d_ready", i), ready, 1);
      chk($sformatf("tbl%0d_data", i), read_data, tbl[i].data);
      chk($sformatf("tbl%0d_sp", i), sp, tbl[i].sp);
      chk($sformatf("tbl%0d_err", i), stack_error, tbl[i].err);
      chk_aerr($sformatf("tbl%0d_aerr", i), tbl[i].op, tbl[i].addr);
    end
    valid = 1'b0;
    step();
    chk("idle_rsp", rsp_valid, 0);
    do_reset();
    pc_op("push_pc", PPC, 32'hDEADBEEF, 32'h0, 'h7FD, 1'b0);
    pc_op("pop_pc", OPC, 32'h0, 32'hDEADBEEF, 'h7FF, 1'b0);
    valid = 1'b1;
    op = PUSH;
    wdata = 16'hAAAA;
    step();
    chk("push1_sp", sp, 'h7FE);
    pc_op("pop_pc_unf", OPC, 32'h0, 32'h0, 'h7FE, 1'b1);
    valid = 1'b1;
    op = POP;
    step();
    chk("pop_after_fault", read_data, 16'hAAAA);
    chk("pop_after_fault_sp", sp, 'h7FF);
    chk("err_sticky", stack_error, 1);
    op = PPC;
    pc = 32'h01234567;
    step();
    chk("abort_b2_ready", ready, 0);
    rst_n = 1'b0;
    valid = 1'b0;
    step();
    chk("abort_rsp", rsp_valid, 0);
    chk("abort_sp", sp, SPR);
    chk("abort_err", stack_error, 0);
    rst_n = 1'b1;
    step();
    chk("abort_idle_rsp", rsp_valid, 0);
    chk("abort_ready", ready, 1);
    for (int a = 0; a < 32; a++) begin
      ram_m[a] = 16'($urandom);
      valid = 1'b1;
      op = WR;
      address = 16'(a);
      wdata = ram_m[a];
      step();
      chk("init_rsp", rsp_valid, 1);
    end
    for (int i = 0; i < 4000; i++) begin
      int r, spm;
      logic [2:0] o;
      logic [15:0] a, ed;
      logic [31:0] epc;
      bit bad;
      r = $urandom_range(0, 99);
      if (i < 2000) o = r < 40 ? PUSH : r < 55 ? PPC : r < 62 ? POP : r < 66 ? OPC : r < 78 ? RD : r < 90 ? WR : r < 95 ? NOP : RSV;
      else o = r < 40 ? POP : r < 55 ? OPC : r < 62 ? PUSH : r < 66 ? PPC : r < 78 ? RD : r < 90 ? WR : r < 95 ? NOP : RSV;
      a = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a[15:11] = 5'($urandom_range(1, 31));
      bad = ACHK && a[15:11] != 0;
      address = a;
      wdata = 16'($urandom);
      pc = $urandom;
      op = o;
      spm = SPR - stk.size();
      if ($urandom_range(0, 9) == 0) begin
        valid = 1'b0;
        step();
        chk("rnd_idle_rsp", rsp_valid, 0);
        chk("rnd_idle_sp", sp, spm);
        continue;
      end
      ed = '0;
      epc = '0;
      case (o)
        RD: ed = bad ? 16'h0 : ram_m[a[4:0]];
        WR: if (!bad) ram_m[a[4:0]] = wdata;
        PUSH: if (spm >= LIM + 1) stk.push_back(wdata); else err_m = 1'b1;
        POP: if (stk.size() >= 1) ed = stk.pop_back(); else err_m = 1'b1;
        PPC: if (spm >= LIM + 2) begin stk.push_back(pc[31:16]); stk.push_back(pc[15:0]); end else err_m = 1'b1;
        OPC: if (stk.size() >= 2) begin epc[15:0] = stk.pop_back(); epc[31:16] = stk.pop_back(); end else err_m = 1'b1;
        default: ;
      endcase
      spm = SPR - stk.size();
      if (o == PPC || o == OPC) pc_op("rnd_pc", o, pc, epc, spm, err_m);
      else begin
        valid = 1'b1;
        step();
        chk("rnd_rsp", rsp_valid, 1);
        chk("rnd_data", read_data, ed);
        chk("rnd_sp", sp, spm);
        chk("rnd_err", stack_error, err_m);
        chk_aerr("rnd_aerr", o, a);
      end
    end
    valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
